// File: rtl/alu_issue_sequencer.sv
// Multi-cycle issue front end for a combinational MIPS ALU.
// Accepts one instruction per handshake, reads operands from an internal
// register file, drives the ALU for one cycle and writes the result back.
// Sequence per instruction: IDLE -> DECODE -> EXEC -> WB -> IDLE.
module alu_issue_sequencer #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr_word,
  output logic [DATA_W-1:0] alu_reg1,
  output logic [DATA_W-1:0] alu_reg2,
  output logic [5:0]        alu_funct,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic              illegal,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 1 << REG_AW;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_AND  = 6'b100100;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [31:0]       instr_q;
  logic [DATA_W-1:0] regs [NREG];
  logic              legal_q;
  logic [REG_AW-1:0] dest_q;

  // Instruction fields of the latched word
  logic [5:0]        op, fn;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [15:0]       imm;
  logic [DATA_W-1:0] rs_val, rt_val, imm_sext, imm_zext;

  // Decode results, registered onto the ALU ports at the end of DECODE
  logic              dec_legal;
  logic [5:0]        dec_funct;
  logic [DATA_W-1:0] dec_a, dec_b;
  logic [REG_AW-1:0] dec_dest;

  assign op  = instr_q[31:26];
  assign rs  = instr_q[25:21];
  assign rt  = instr_q[20:16];
  assign rd  = instr_q[15:11];
  assign imm = instr_q[15:0];
  assign fn  = instr_q[5:0];

  assign rs_val   = (rs == '0) ? '0 : regs[rs];
  assign rt_val   = (rt == '0) ? '0 : regs[rt];
  assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_zext = {{(DATA_W-16){1'b0}}, imm};

  // Debug port reads the array directly, so a write in WB is visible only afterwards
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  // Decode: unsupported encodings issue a harmless addu 0+0
  always_comb begin
    dec_legal = 1'b0;
    dec_funct = FN_ADDU;
    dec_a     = '0;
    dec_b     = '0;
    dec_dest  = '0;
    case (op)
      6'b000000: begin
        if (fn == FN_ADD || fn == FN_ADDU || fn == FN_AND) begin
          dec_legal = 1'b1;
          dec_funct = fn;
          dec_a     = rs_val;
          dec_b     = rt_val;
          dec_dest  = rd;
        end
      end
      6'b001000: begin
        dec_legal = 1'b1;
        dec_funct = FN_ADD;
        dec_a     = rs_val;
        dec_b     = imm_sext;
        dec_dest  = rt;
      end
      6'b001001: begin
        dec_legal = 1'b1;
        dec_funct = FN_ADDU;
        dec_a     = rs_val;
        dec_b     = imm_sext;
        dec_dest  = rt;
      end
      6'b001100: begin
        dec_legal = 1'b1;
        dec_funct = FN_AND;
        dec_a     = rs_val;
        dec_b     = imm_zext;
        dec_dest  = rt;
      end
      default: ;
    endcase
  end

  // Next-state logic and state-derived handshake/retire pulses
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_WB;
      S_WB: begin
        done      = legal_q;
        illegal   = ~legal_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Datapath: latch, issue, capture result (wb_data doubles as the result register), write back
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= '0;
      alu_reg1  <= '0;
      alu_reg2  <= '0;
      alu_funct <= FN_ADDU;
      legal_q   <= 1'b0;
      dest_q    <= '0;
      wb_addr   <= '0;
      wb_data   <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      // IDLE -> DECODE
      if (state == S_IDLE && instr_valid) instr_q <= instr_word;
      // DECODE -> EXEC
      if (state == S_DECODE) begin
        alu_reg1  <= dec_a;
        alu_reg2  <= dec_b;
        alu_funct <= dec_funct;
        legal_q   <= dec_legal;
        dest_q    <= dec_dest;
      end
      // EXEC -> WB: illegal instructions leave wb_* untouched
      if (state == S_EXEC && legal_q) begin
        wb_addr <= dest_q;
        wb_data <= alu_result;
      end
      // WB -> IDLE
      if (state == S_WB && legal_q && wb_addr != '0) regs[wb_addr] <= wb_data;
    end
  end

endmodule
